lane_register_bank: RTL and testbench

Parametrised bank of DEPTH lane registers, each WIDTH bits wide. Supports parallel load, serial shift-in with fill tracking, and lane rotation. Sits between the permutation datapath and its state storage, replacing individual single-word load registers. Presents every lane in parallel and the oldest lane serially.

---
 rtl/lane_register_bank_pkg.sv | 28 ++
 rtl/lane_register_bank_if.sv | 30 +++
 rtl/lane_register_bank_lane_cell.sv | 31 +++
 rtl/lane_register_bank.sv | 94 +++++++++
 tb/tb_lane_register_bank.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/lane_register_bank_pkg.sv
// Shared types for the lane register bank: command priority encoding,
// per-lane next-value select, and a width helper for the fill counter.
package lane_bank_pkg;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_ROT,
    CMD_SHIFT,
    CMD_LD,
    CMD_CLR
  } cmd_e;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_ZERO,
    SEL_PAR,
    SEL_NBR
  } sel_e;

  // Bits needed to index n values; callers pass DEPTH+1 so the result is >= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/lane_register_bank_if.sv
// Command/data bundle of the lane register bank; master drives commands,
// slave (the bank) returns the lane contents and fill status.
interface lane_register_bank_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 5
);
  localparam int CNT_W = lane_bank_pkg::clog2(DEPTH + 1);

  logic                   clr;
  logic                   ld;
  logic                   shift_en;
  logic                   rot_en;
  logic [DEPTH*WIDTH-1:0] par_in;
  logic [WIDTH-1:0]       ser_in;
  logic [DEPTH*WIDTH-1:0] par_out;
  logic [WIDTH-1:0]       ser_out;
  logic [CNT_W-1:0]       fill_cnt;
  logic                   full;
  logic                   done;

  modport master (
    output clr, ld, shift_en, rot_en, par_in, ser_in,
    input  par_out, ser_out, fill_cnt, full, done
  );

  modport slave (
    input  clr, ld, shift_en, rot_en, par_in, ser_in,
    output par_out, ser_out, fill_cnt, full, done
  );
endinterface

// File: rtl/lane_register_bank_lane_cell.sv
// One lane of the bank: a WIDTH-bit register whose next value is chosen
// from hold, zero, parallel input or its neighbour lane.
module lane_cell
  import lane_bank_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  sel_e             sel,
  input  logic [WIDTH-1:0] par,
  input  logic [WIDTH-1:0] nbr,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking (<=) so every lane samples its
  // neighbour's pre-edge value; blocking here would smear a shift across lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_ZERO: q <= '0;
        SEL_PAR:  q <= par;
        SEL_NBR:  q <= nbr;
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/lane_register_bank.sv
// Bank of DEPTH lane registers with parallel load, serial shift-in with fill
// tracking, and rotation. Holds the command decode, fill counter and done flop.
module lane_register_bank
  import lane_bank_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 5
) (
  input logic                clk,
  input logic                rst,
  lane_register_bank_if.slave bus
);

  localparam int               CNT_W    = clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  cmd_e                   cmd;
  sel_e                   sel;
  logic [WIDTH-1:0]       lane [DEPTH];
  logic [DEPTH*WIDTH-1:0] par_flat;
  logic [CNT_W-1:0]       fill_cnt;
  logic                   done;

  // NOTE: every always_comb output gets a value on every path (final else /
  // default) so no latch is inferred.
  always_comb begin
    if (bus.clr)           cmd = CMD_CLR;
    else if (bus.ld)       cmd = CMD_LD;
    else if (bus.shift_en) cmd = CMD_SHIFT;
    else if (bus.rot_en)   cmd = CMD_ROT;
    else                   cmd = CMD_HOLD;
  end

  always_comb begin
    case (cmd)
      CMD_CLR:            sel = SEL_ZERO;
      CMD_LD:             sel = SEL_PAR;
      CMD_SHIFT, CMD_ROT: sel = SEL_NBR;
      default:            sel = SEL_HOLD;
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    logic [WIDTH-1:0] nbr;

    // Lane 0 takes ser_in on shift and wraps the oldest lane on rotate.
    if (i == 0) begin : g_head
      assign nbr = (cmd == CMD_SHIFT) ? bus.ser_in : lane[DEPTH-1];
    end else begin : g_body
      assign nbr = lane[i-1];
    end

    lane_cell #(.WIDTH(WIDTH)) u_cell (
      .clk (clk),
      .rst (rst),
      .sel (sel),
      .par (bus.par_in[i*WIDTH +: WIDTH]),
      .nbr (nbr),
      .q   (lane[i])
    );
  end

  always_comb begin
    par_flat = '0;
    for (int i = 0; i < DEPTH; i++) par_flat[i*WIDTH +: WIDTH] = lane[i];
  end

  // Fill count saturates at DEPTH; done marks only the shift that fills the bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (cmd)
        CMD_CLR: fill_cnt <= '0;
        CMD_LD:  fill_cnt <= FULL_CNT;
        CMD_SHIFT: begin
          if (fill_cnt != FULL_CNT) fill_cnt <= fill_cnt + CNT_W'(1);
          done <= (fill_cnt == LAST_CNT);
        end
        default: ;
      endcase
    end
  end

  assign bus.par_out  = par_flat;
  assign bus.ser_out  = lane[DEPTH-1];
  assign bus.fill_cnt = fill_cnt;
  assign bus.full     = (fill_cnt == FULL_CNT);
  assign bus.done     = done;

endmodule

// File: tb/tb_lane_register_bank.sv
// Self-checking bench for lane_register_bank: WIDTH=8/DEPTH=4 vector table,
// hand-written reset and DEPTH=1 sequences, then random commands vs a queue model.
module tb_lane_register_bank;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  lane_register_bank_if #(.WIDTH(W), .DEPTH(D)) bus4 ();
  lane_register_bank_if #(.WIDTH(W), .DEPTH(1)) bus1 ();

  lane_register_bank #(.WIDTH(W), .DEPTH(D)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  lane_register_bank #(.WIDTH(W), .DEPTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Reference model: queue index 0 is lane 0 (newest), index D-1 the oldest.
  logic [W-1:0] m_q[$];
  int           m_fill;
  bit           m_done;

  typedef struct {
    bit          clr;
    bit          ld;
    bit          sh;
    bit          rot;
    logic [31:0] par;
    logic [7:0]  ser;
    logic [31:0] e_par;
    int          e_fill;
    bit          e_done;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    repeat (D) m_q.push_back('0);
    m_fill = 0;
    m_done = 1'b0;
  endfunction

  function automatic void model_step(input bit c, input bit l, input bit s, input bit r,
                                     input logic [31:0] par, input logic [7:0] ser);
    if (c) begin
      model_reset();
    end else if (l) begin
      m_q.delete();
      for (int i = 0; i < D; i++) m_q.push_back(par[i*W +: W]);
      m_fill = D;
      m_done = 1'b0;
    end else if (s) begin
      m_done = (m_fill == D - 1);
      m_q.push_front(ser);
      void'(m_q.pop_back());
      if (m_fill < D) m_fill++;
    end else if (r) begin
      m_q.push_front(m_q.pop_back());
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
    end
  endfunction

  function automatic logic [31:0] model_par();
    logic [31:0] p;
    for (int i = 0; i < D; i++) p[i*W +: W] = m_q[i];
    return p;
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_par"},  bus4.par_out,  model_par());
    check({tag, "_ser"},  bus4.ser_out,  m_q[D-1]);
    check({tag, "_fill"}, bus4.fill_cnt, m_fill);
    check({tag, "_full"}, bus4.full,     m_fill == D);
    check({tag, "_done"}, bus4.done,     m_done);
  endtask

  // Drive one command to the DEPTH=4 bank, clock it, and leave off on a negedge.
  task automatic drive4(input bit c, input bit l, input bit s, input bit r,
                        input logic [31:0] par, input logic [7:0] ser);
    bus4.clr = c; bus4.ld = l; bus4.shift_en = s; bus4.rot_en = r;
    bus4.par_in = par; bus4.ser_in = ser;
    @(posedge clk);
    model_step(c, l, s, r, par, ser);
    @(negedge clk);
  endtask

  task automatic drive1(input bit s, input bit r, input logic [7:0] ser);
    bus1.clr = 1'b0; bus1.ld = 1'b0; bus1.shift_en = s; bus1.rot_en = r;
    bus1.par_in = '0; bus1.ser_in = ser;
    drive4(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    vecs[0]  = '{0, 0, 1, 0, 32'h0,        8'h11, 32'h0000_0011, 1, 0};
    vecs[1]  = '{0, 0, 1, 0, 32'h0,        8'h22, 32'h0000_1122, 2, 0};
    vecs[2]  = '{0, 0, 1, 0, 32'h0,        8'h33, 32'h0011_2233, 3, 0};
    vecs[3]  = '{0, 0, 1, 0, 32'h0,        8'h44, 32'h1122_3344, 4, 1};
    vecs[4]  = '{0, 0, 1, 0, 32'h0,        8'h55, 32'h2233_4455, 4, 0};
    vecs[5]  = '{0, 0, 0, 0, 32'h0,        8'h66, 32'h2233_4455, 4, 0};
    vecs[6]  = '{0, 1, 0, 0, 32'hA3A2_A1A0, 8'h00, 32'hA3A2_A1A0, 4, 0};
    vecs[7]  = '{0, 0, 0, 1, 32'h0,        8'h00, 32'hA2A1_A0A3, 4, 0};
    vecs[8]  = '{1, 1, 1, 0, 32'hFFFF_FFFF, 8'h99, 32'h0000_0000, 0, 0};
    vecs[9]  = '{0, 1, 1, 0, 32'h1234_5678, 8'h99, 32'h1234_5678, 4, 0};
    vecs[10] = '{1, 0, 0, 0, 32'h0,        8'h00, 32'h0000_0000, 0, 0};
    vecs[11] = '{0, 0, 1, 1, 32'h0,        8'h5A, 32'h0000_005A, 1, 0};
    vecs[12] = '{0, 0, 0, 1, 32'h0,        8'h00, 32'h0000_5A00, 1, 0};

    bus4.clr = 0; bus4.ld = 0; bus4.shift_en = 0; bus4.rot_en = 0;
    bus4.par_in = '0; bus4.ser_in = '0;
    bus1.clr = 0; bus1.ld = 0; bus1.shift_en = 0; bus1.rot_en = 0;
    bus1.par_in = '0; bus1.ser_in = '0;
    model_reset();

    #2;
    check_model("reset");
    check("reset_d1_fill", bus1.fill_cnt, 0);
    check("reset_d1_par",  bus1.par_out,  0);
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-fill: outputs clear without an edge, fill restarts at 0.
    drive4(0, 0, 1, 0, '0, 8'h11);
    drive4(0, 0, 1, 0, '0, 8'h22);
    check_model("midfill");
    bus4.shift_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_par",  bus4.par_out,  0);
    check("async_rst_ser",  bus4.ser_out,  0);
    check("async_rst_fill", bus4.fill_cnt, 0);
    check("async_rst_full", bus4.full,     0);
    check("async_rst_done", bus4.done,     0);
    #1 rst = 1'b1;
    model_reset();
    drive4(0, 0, 0, 0, '0, '0);
    check_model("post_rst");

    for (int i = 0; i < 13; i++) begin
      drive4(vecs[i].clr, vecs[i].ld, vecs[i].sh, vecs[i].rot, vecs[i].par, vecs[i].ser);
      check($sformatf("vec%0d_par", i),  bus4.par_out,  vecs[i].e_par);
      check($sformatf("vec%0d_ser", i),  bus4.ser_out,  vecs[i].e_par[31:24]);
      check($sformatf("vec%0d_fill", i), bus4.fill_cnt, vecs[i].e_fill);
      check($sformatf("vec%0d_full", i), bus4.full,     vecs[i].e_fill == D);
      check($sformatf("vec%0d_done", i), bus4.done,     vecs[i].e_done);
    end

    // DEPTH=1: a single shift fills the bank; rotation leaves it unchanged.
    drive1(1, 0, 8'h7E);
    check("d1_shift_par",  bus1.par_out,  8'h7E);
    check("d1_shift_fill", bus1.fill_cnt, 1);
    check("d1_shift_full", bus1.full,     1);
    check("d1_shift_done", bus1.done,     1);
    drive1(0, 0, 8'h00);
    check("d1_hold_done",  bus1.done,     0);
    check("d1_hold_fill",  bus1.fill_cnt, 1);
    drive1(0, 1, 8'h00);
    check("d1_rot_par",    bus1.par_out,  8'h7E);
    check("d1_rot_ser",    bus1.ser_out,  8'h7E);
    check("d1_rot_done",   bus1.done,     0);
    drive1(1, 0, 8'h3C);
    check("d1_full_shift_par",  bus1.par_out, 8'h3C);
    check("d1_full_shift_done", bus1.done,    0);
    check("d1_full_shift_full", bus1.full,    1);
    check_model("d1_phase");

    for (int n = 0; n < 400; n++) begin
      drive4($urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 1) == 1,  $urandom_range(0, 3) == 0,
             $urandom, 8'($urandom));
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
